// File: rtl/apb_reg_slave_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : apb_reg_slave_pkg                                            |
// | Description : Shared APB FSM encoding and default bus widths.              |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package apb_reg_slave_pkg;

   localparam int unsigned APB_DATA_BW_DEF = 8;
   localparam int unsigned APB_ADDR_BW_DEF = 8;
   localparam int unsigned WAIT_CNT_BW     = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

endpackage : apb_reg_slave_pkg
`default_nettype wire

// File: rtl/apb_slv_wait_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : apb_slv_wait_ctr                                             |
// | Description : Wait-state counter; done once WAIT_CYC access cycles elapsed.|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module apb_slv_wait_ctr
   import apb_reg_slave_pkg::*;
#(
   parameter int unsigned WAIT_CYC = 1
)(
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic done
);

   localparam logic [WAIT_CNT_BW-1:0] WAIT_LIM = WAIT_CNT_BW'(WAIT_CYC);

   logic [WAIT_CNT_BW-1:0] cnt_q;
   logic [WAIT_CNT_BW-1:0] cnt_d;

   // Saturates at WAIT_LIM so done stays high until the next clear.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != WAIT_LIM)) begin
         cnt_d = cnt_q + WAIT_CNT_BW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == WAIT_LIM);

endmodule : apb_slv_wait_ctr
`default_nettype wire

// File: rtl/apb_reg_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : apb_reg_slave                                                |
// | Description : APB3 completer with REG_NUM R/W registers and wait states.   |
// |               Define APB_SLV_PSLVERR_EN to add the pslverr output.         |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module apb_reg_slave
   import apb_reg_slave_pkg::*;
#(
   parameter int unsigned DATA_BW  = APB_DATA_BW_DEF,
   parameter int unsigned ADDR_BW  = APB_ADDR_BW_DEF,
   parameter int unsigned REG_NUM  = 16,
   parameter int unsigned WAIT_CYC = 1
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       psel,
   input  logic                       penable,
   input  logic                       pwrite,
   input  logic [ADDR_BW-1:0]         paddr,
   input  logic [DATA_BW-1:0]         pwdata,
   output logic [DATA_BW-1:0]         prdata,
   output logic                       pready,
   output logic [REG_NUM*DATA_BW-1:0] reg_q
`ifdef APB_SLV_PSLVERR_EN
   ,
   output logic                       pslverr
`endif
);

   apb_state_e                 state_q;
   apb_state_e                 state_d;
   logic                       ctr_done;
   logic                       wr_en;
   logic [DATA_BW-1:0]         rd_mux;
   logic [DATA_BW-1:0]         prdata_q;
   logic [DATA_BW-1:0]         prdata_d;
   logic [REG_NUM*DATA_BW-1:0] regs_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (psel && !penable) state_d = SETUP;
         SETUP:   state_d = ACCESS;
         ACCESS:  if (!psel || pready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   apb_slv_wait_ctr #(
      .WAIT_CYC (WAIT_CYC)
   ) u_wait_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_q == SETUP),
      .en    (state_q == ACCESS),
      .done  (ctr_done)
   );

   // psel qualifies pready so an abandoned access never completes or writes.
   assign pready = (state_q == ACCESS) && ctr_done && psel;
   assign wr_en  = pready && pwrite;

   always_comb begin
      rd_mux = '0;
      for (int unsigned i = 0; i < REG_NUM; i++) begin
         if (paddr == ADDR_BW'(i)) rd_mux = regs_q[i*DATA_BW +: DATA_BW];
      end
   end

   always_comb begin
      prdata_d = '0;
      if (state_q == SETUP) begin
         prdata_d = rd_mux;
      end else if ((state_q == ACCESS) && (state_d == ACCESS)) begin
         prdata_d = prdata_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prdata_q <= '0;
      end else begin
         prdata_q <= prdata_d;
      end
   end

   for (genvar g = 0; g < REG_NUM; g++) begin : g_regs
      logic [DATA_BW-1:0] data_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            data_q <= '0;
         end else if (wr_en && (paddr == ADDR_BW'(g))) begin
            data_q <= pwdata;
         end
      end

      assign regs_q[g*DATA_BW +: DATA_BW] = data_q;
   end

   assign reg_q  = regs_q;
   assign prdata = prdata_q;

`ifdef APB_SLV_PSLVERR_EN
   localparam logic [ADDR_BW:0] REG_LIM = (ADDR_BW+1)'(REG_NUM);

   logic in_range;

   assign in_range = ({1'b0, paddr} < REG_LIM);
   assign pslverr  = pready && !in_range;
`endif

endmodule : apb_reg_slave
`default_nettype wire

// File: tb/tb_apb_reg_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_apb_reg_slave                                             |
// | Description : Two apb_reg_slave instances (WAIT_CYC 0 and 1) checked       |
// |               against a register-file model. Revision 1.0                  |
// +----------------------------------------------------------------------------+
module tb_apb_reg_slave;

   localparam int DW     = 8;
   localparam int AW     = 8;
   localparam int RN     = 16;
   localparam int NDUT   = 2;
   localparam int W_DUT0 = 0;
   localparam int W_DUT1 = 1;

   typedef logic [RN*DW-1:0] wide_t;

   typedef struct {
      int            d;
      bit            wr;
      int            addr;
      logic [DW-1:0] data;
      logic [DW-1:0] exp_rd;
   } tvec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n   [NDUT];
   logic          psel    [NDUT];
   logic          penable [NDUT];
   logic          pwrite  [NDUT];
   logic [AW-1:0] paddr   [NDUT];
   logic [DW-1:0] pwdata  [NDUT];
   logic [DW-1:0] prdata  [NDUT];
   logic          pready  [NDUT];
   wide_t         reg_q   [NDUT];
`ifdef APB_SLV_PSLVERR_EN
   logic          pslverr [NDUT];
`endif

   apb_reg_slave #(.DATA_BW(DW), .ADDR_BW(AW), .REG_NUM(RN), .WAIT_CYC(W_DUT0)) u_dut0 (
      .clk     (clk),
      .rst_n   (rst_n[0]),
      .psel    (psel[0]),
      .penable (penable[0]),
      .pwrite  (pwrite[0]),
      .paddr   (paddr[0]),
      .pwdata  (pwdata[0]),
      .prdata  (prdata[0]),
      .pready  (pready[0]),
`ifdef APB_SLV_PSLVERR_EN
      .pslverr (pslverr[0]),
`endif
      .reg_q   (reg_q[0])
   );

   apb_reg_slave #(.DATA_BW(DW), .ADDR_BW(AW), .REG_NUM(RN), .WAIT_CYC(W_DUT1)) u_dut1 (
      .clk     (clk),
      .rst_n   (rst_n[1]),
      .psel    (psel[1]),
      .penable (penable[1]),
      .pwrite  (pwrite[1]),
      .paddr   (paddr[1]),
      .pwdata  (pwdata[1]),
      .prdata  (prdata[1]),
      .pready  (pready[1]),
`ifdef APB_SLV_PSLVERR_EN
      .pslverr (pslverr[1]),
`endif
      .reg_q   (reg_q[1])
   );

   logic [DW-1:0] mem [NDUT][RN];
   int tests = 0;
   int fails = 0;

   function automatic int wait_of(input int d);
      return (d == 0) ? W_DUT0 : W_DUT1;
   endfunction

   function automatic wide_t model_vec(input int d);
      wide_t v;
      v = '0;
      for (int i = 0; i < RN; i++) v[i*DW +: DW] = mem[d][i];
      return v;
   endfunction

   task automatic check(input string name, input int d, input wide_t act, input wide_t exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s dut%0d: actual %0h required %0h", name, d, act, exp);
      end
   endtask

   task automatic model_clear(input int d);
      for (int i = 0; i < RN; i++) mem[d][i] = '0;
   endtask

   task automatic bus_idle(input int d);
      @(posedge clk); #1;
      psel[d]    = 1'b0;
      penable[d] = 1'b0;
   endtask

   // One complete transfer; latency counted in penable cycles including the pready cycle.
   task automatic apb_xfer(input int d, input bit wr, input int addr,
                           input logic [DW-1:0] data, output logic [DW-1:0] rd);
      int            k;
      int            exp_k;
      bit            seen;
      logic [DW-1:0] exp_rd;
      exp_k  = 2 + wait_of(d);
      exp_rd = (addr < RN) ? mem[d][addr] : '0;
      rd     = '0;
      @(posedge clk); #1;
      psel[d]    = 1'b1;
      penable[d] = 1'b0;
      pwrite[d]  = wr;
      paddr[d]   = AW'(addr);
      pwdata[d]  = data;
      @(negedge clk);
      check("setup_pready", d, wide_t'(pready[d]), '0);
      check("idle_prdata", d, wide_t'(prdata[d]), '0);
      check("reg_q", d, reg_q[d], model_vec(d));
      @(posedge clk); #1;
      penable[d] = 1'b1;
      k    = 0;
      seen = 1'b0;
      while (!seen && (k < exp_k + 4)) begin
         k++;
         @(negedge clk);
         seen = (pready[d] === 1'b1);
      end
      check("latency", d, wide_t'(k), wide_t'(exp_k));
      rd = prdata[d];
      if (!wr) check("rdata", d, wide_t'(rd), wide_t'(exp_rd));
`ifdef APB_SLV_PSLVERR_EN
      check("pslverr", d, wide_t'(pslverr[d]), wide_t'(addr >= RN));
`endif
      if (wr && seen && (addr < RN)) mem[d][addr] = data;
   endtask

   initial begin
      tvec_t         tbl [13];
      logic [DW-1:0] rd;
      int            last_d;
      int            addr;
      bit            wr;

      tbl[0]  = '{1, 1'b0,  3, 8'h00, 8'h00};
      tbl[1]  = '{1, 1'b1,  2, 8'hA5, 8'h00};
      tbl[2]  = '{1, 1'b0,  2, 8'h00, 8'hA5};
      tbl[3]  = '{1, 1'b1, 20, 8'h5A, 8'h00};
      tbl[4]  = '{1, 1'b0, 20, 8'h00, 8'h00};
      tbl[5]  = '{1, 1'b0,  2, 8'h00, 8'hA5};
      tbl[6]  = '{0, 1'b1,  0, 8'h11, 8'h00};
      tbl[7]  = '{0, 1'b1,  1, 8'h22, 8'h00};
      tbl[8]  = '{0, 1'b0,  0, 8'h00, 8'h11};
      tbl[9]  = '{0, 1'b0,  1, 8'h00, 8'h22};
      tbl[10] = '{0, 1'b1, 20, 8'h5A, 8'h00};
      tbl[11] = '{0, 1'b0, 20, 8'h00, 8'h00};
      tbl[12] = '{0, 1'b0,  1, 8'h00, 8'h22};

      for (int d = 0; d < NDUT; d++) begin
         rst_n[d]   = 1'b0;
         psel[d]    = 1'b0;
         penable[d] = 1'b0;
         pwrite[d]  = 1'b0;
         paddr[d]   = '0;
         pwdata[d]  = '0;
         model_clear(d);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
         check("rst_reg_q", d, reg_q[d], '0);
         check("rst_pready", d, wide_t'(pready[d]), '0);
         check("rst_prdata", d, wide_t'(prdata[d]), '0);
      end

      // Directed table, back-to-back within each instance.
      last_d = -1;
      for (int i = 0; i < 13; i++) begin
         if ((last_d >= 0) && (tbl[i].d != last_d)) bus_idle(last_d);
         apb_xfer(tbl[i].d, tbl[i].wr, tbl[i].addr, tbl[i].data, rd);
         if (!tbl[i].wr) check("tbl_rdata", tbl[i].d, wide_t'(rd), wide_t'(tbl[i].exp_rd));
         last_d = tbl[i].d;
      end
      bus_idle(last_d);

      for (int d = 0; d < NDUT; d++) begin
         // psel and penable together while idle must be ignored.
         @(posedge clk); #1;
         psel[d] = 1'b1; penable[d] = 1'b1; pwrite[d] = 1'b1;
         paddr[d] = AW'(6); pwdata[d] = 8'h3C;
         repeat (3) begin
            @(negedge clk);
            check("idle_penable_pready", d, wide_t'(pready[d]), '0);
         end
         bus_idle(d);

         // psel dropped in the access phase: no completion, no write.
         @(posedge clk); #1;
         psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = 1'b1;
         paddr[d] = AW'(5); pwdata[d] = 8'h77;
         @(posedge clk); #1;
         penable[d] = 1'b1;
         @(posedge clk); #1;
         psel[d] = 1'b0; penable[d] = 1'b0;
         repeat (3) begin
            @(negedge clk);
            check("drop_pready", d, wide_t'(pready[d]), '0);
         end
         apb_xfer(d, 1'b0, 5, 8'h00, rd);
         bus_idle(d);

         // Reset asserted during the access phase of a write.
         @(posedge clk); #1;
         psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = 1'b1;
         paddr[d] = AW'(4); pwdata[d] = 8'hFF;
         @(posedge clk); #1;
         penable[d] = 1'b1;
         @(posedge clk);
         @(negedge clk);
         #1;
         rst_n[d] = 1'b0;
         model_clear(d);
         #1;
         check("midrst_pready", d, wide_t'(pready[d]), '0);
         check("midrst_reg_q", d, reg_q[d], '0);
         check("midrst_prdata", d, wide_t'(prdata[d]), '0);
         psel[d] = 1'b0; penable[d] = 1'b0;
         @(posedge clk);
         @(posedge clk); #1;
         rst_n[d] = 1'b1;
         apb_xfer(d, 1'b1, 4, 8'hFF, rd);
         apb_xfer(d, 1'b0, 4, 8'h00, rd);
         check("post_rst_rdata", d, wide_t'(rd), wide_t'(8'hFF));
         bus_idle(d);
      end

      // Randomized traffic including out-of-range addresses and idle gaps.
      for (int d = 0; d < NDUT; d++) begin
         for (int n = 0; n < 150; n++) begin
            wr   = bit'($urandom_range(0, 1));
            addr = int'($urandom_range(0, RN + 7));
            apb_xfer(d, wr, addr, DW'($urandom), rd);
            if ($urandom_range(0, 2) == 0) bus_idle(d);
         end
         apb_xfer(d, 1'b0, 0, 8'h00, rd);
         bus_idle(d);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
      $fatal(1);
   end

endmodule : tb_apb_reg_slave
`default_nettype wire
